// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, with a
// start/done handshake. Results are registered and only change on completion.
module serial_addsub #(
  parameter int BW_DATA = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_sub,
  input  logic [BW_DATA-1:0] i_a,
  input  logic [BW_DATA-1:0] i_b,
  input  logic               i_c,
  output logic               o_busy,
  output logic               o_done,
  output logic [BW_DATA-1:0] o_s,
  output logic               o_c
);

  // Handshake: i_start is accepted only in IDLE or DONE. o_busy is high for
  // exactly BW_DATA cycles, then o_done pulses for one cycle, during which
  // o_s/o_c are already valid and a new i_start is accepted back-to-back.
  localparam int CW = $clog2(BW_DATA + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BW_DATA - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [BW_DATA-1:0] a_q;
  logic [BW_DATA-1:0] b_q;
  logic [BW_DATA-1:0] res_q;
  logic [BW_DATA-1:0] res_d;
  logic [CW-1:0]      cnt_q;
  logic               cy_q;
  logic               cy_d;
  logic               sub_q;
  logic               bit_d;
  logic               last_d;

  // Subtraction is A + ~B + ~borrow_in; the final carry is the inverted borrow.
  always_comb begin
    bit_d  = a_q[0] ^ b_q[0] ^ cy_q;
    cy_d   = (a_q[0] & b_q[0]) | (a_q[0] & cy_q) | (b_q[0] & cy_q);
    res_d  = res_q >> 1;
    res_d[BW_DATA-1] = bit_d;
    last_d = (cnt_q == LAST_CNT);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      sub_q   <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_s     <= '0;
      o_c     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            a_q     <= i_a;
            b_q     <= i_sub ? ~i_b : i_b;
            cy_q    <= i_sub ^ i_c;
            sub_q   <= i_sub;
            res_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_RUN;
            o_busy  <= 1'b1;
            o_done  <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
          end
        end
        ST_RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          cy_q  <= cy_d;
          res_q <= res_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_d) begin
            o_s     <= res_d;
            o_c     <= sub_q ^ cy_d;
            state_q <= ST_DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and random checks of serial_addsub at widths 8, 1 and 16, compared
// against a plain-arithmetic reference model.
module tb_serial_addsub;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;

  logic        busy8, done8, c8;
  logic [7:0]  s8;
  logic        busy1, done1, c1;
  logic [0:0]  s1;
  logic        busy16, done16, c16;
  logic [15:0] s16;

  int total = 0;
  int bad   = 0;

  logic [31:0] last_s[17];
  bit          known[17];

  serial_addsub #(.BW_DATA(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sub(sub),
    .i_a(a[7:0]), .i_b(b[7:0]), .i_c(cin),
    .o_busy(busy8), .o_done(done8), .o_s(s8), .o_c(c8)
  );

  serial_addsub #(.BW_DATA(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sub(sub),
    .i_a(a[0:0]), .i_b(b[0:0]), .i_c(cin),
    .o_busy(busy1), .o_done(done1), .o_s(s1), .o_c(c1)
  );

  serial_addsub #(.BW_DATA(16)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sub(sub),
    .i_a(a), .i_b(b), .i_c(cin),
    .o_busy(busy16), .o_done(done16), .o_s(s16), .o_c(c16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] get_s(int w);
    case (w)
      1:       return {31'd0, s1};
      8:       return {24'd0, s8};
      default: return {16'd0, s16};
    endcase
  endfunction

  function automatic logic get_c(int w);
    case (w)
      1:       return c1;
      8:       return c8;
      default: return c16;
    endcase
  endfunction

  function automatic logic get_busy(int w);
    case (w)
      1:       return busy1;
      8:       return busy8;
      default: return busy16;
    endcase
  endfunction

  function automatic logic get_done(int w);
    case (w)
      1:       return done1;
      8:       return done8;
      default: return done16;
    endcase
  endfunction

  // reference model: plain integer arithmetic
  function automatic void model(int w, bit sub_v, bit c_v, longint a_v, longint b_v,
                                output logic [31:0] s_e, output logic c_e);
    longint m;
    longint t;
    m = longint'(1) << w;
    if (!sub_v) begin
      t   = a_v + b_v + longint'(c_v);
      s_e = 32'(t % m);
      c_e = (t >= m);
    end else begin
      t   = a_v - b_v - longint'(c_v);
      s_e = 32'(((t % m) + m) % m);
      c_e = (a_v < b_v + longint'(c_v));
    end
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    foreach (known[i]) begin
      known[i]  = 1'b1;
      last_s[i] = 32'd0;
    end
  endtask

  task automatic start_op(bit sub_v, bit c_v, logic [15:0] a_v, logic [15:0] b_v);
    @(negedge clk);
    sub   = sub_v;
    cin   = c_v;
    a     = a_v;
    b     = b_v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until o_done, optionally checking o_s holds its old value.
  task automatic wait_done(int w, logic [31:0] hold_s, bit hold_chk, string tag,
                           int first, output int edges);
    bit seen;
    seen  = 1'b0;
    edges = first;
    while (!seen && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (get_done(w)) seen = 1'b1;
      else if (hold_chk) check({tag, "_hold"}, get_s(w), hold_s);
    end
  endtask

  task automatic run_check(int w, bit sub_v, bit c_v, logic [15:0] a_v, logic [15:0] b_v,
                           string tag);
    logic [31:0] s_e;
    logic        c_e;
    int          edges;
    model(w, sub_v, c_v, longint'(a_v), longint'(b_v), s_e, c_e);
    start_op(sub_v, c_v, a_v, b_v);
    check({tag, "_busy"}, 32'(get_busy(w)), 32'd1);
    wait_done(w, last_s[w], known[w], tag, 0, edges);
    check({tag, "_lat"}, 32'(edges), 32'(w));
    check({tag, "_s"}, get_s(w), s_e);
    check({tag, "_c"}, 32'(get_c(w)), 32'(c_e));
    last_s[w] = s_e;
    known[w]  = 1'b1;
  endtask

  initial begin
    int          edges;
    int          seen_done;
    int          widths[3];
    logic [31:0] mask;
    logic [15:0] ra, rb;
    bit          rs, rc;

    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    do_reset();

    check("rst_busy8",  32'(busy8),  32'd0);
    check("rst_done8",  32'(done8),  32'd0);
    check("rst_s8",     get_s(8),    32'd0);
    check("rst_c8",     32'(c8),     32'd0);
    check("rst_busy1",  32'(busy1),  32'd0);
    check("rst_s1",     get_s(1),    32'd0);
    check("rst_busy16", 32'(busy16), 32'd0);
    check("rst_s16",    get_s(16),   32'd0);

    // directed, width 8
    run_check(8, 1'b0, 1'b0, 16'h7F, 16'h01, "add_7f_01");
    check("add_7f_01_s_lit", get_s(8), 32'h80);
    @(posedge clk);
    #1;
    check("add_7f_01_done_drop", 32'(done8), 32'd0);

    run_check(8, 1'b0, 1'b1, 16'hFF, 16'h01, "add_ff_01_c");
    check("add_ff_01_c_s_lit", get_s(8), 32'h01);
    check("add_ff_01_c_c_lit", 32'(c8), 32'd1);
    run_check(8, 1'b1, 1'b0, 16'h05, 16'h07, "sub_05_07");
    check("sub_05_07_s_lit", get_s(8), 32'hFE);
    run_check(8, 1'b1, 1'b1, 16'h10, 16'h10, "sub_10_10_c");
    check("sub_10_10_c_s_lit", get_s(8), 32'hFF);
    check("sub_10_10_c_c_lit", 32'(c8), 32'd1);
    run_check(8, 1'b1, 1'b0, 16'h20, 16'h10, "sub_20_10");
    check("sub_20_10_c_lit", 32'(c8), 32'd0);

    // start during RUN is ignored; start during DONE is accepted
    start_op(1'b1, 1'b0, 16'h40, 16'h08);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    start_op(1'b0, 1'b0, 16'h99, 16'h01);
    wait_done(8, 32'h10, 1'b1, "mid_start", 3, edges);
    check("mid_start_lat", 32'(edges), 32'd8);
    check("mid_start_s", get_s(8), 32'h38);
    check("mid_start_c", 32'(c8), 32'd0);
    start_op(1'b0, 1'b0, 16'h11, 16'h22);
    check("b2b_done_low", 32'(done8), 32'd0);
    check("b2b_busy", 32'(busy8), 32'd1);
    wait_done(8, 32'h38, 1'b1, "b2b", 0, edges);
    check("b2b_lat", 32'(edges), 32'd8);
    check("b2b_s", get_s(8), 32'h33);
    last_s[8] = 32'h33;

    // reset mid-operation, then reset colliding with start
    start_op(1'b0, 1'b0, 16'h55, 16'h22);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_s",    get_s(8),   32'd0);
    check("midrst_c",    32'(c8),    32'd0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("rst_start_busy", 32'(busy8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done8) seen_done++;
    end
    check("midrst_no_done", 32'(seen_done), 32'd0);
    last_s[8] = 32'd0;
    known[8]  = 1'b1;
    run_check(8, 1'b0, 1'b0, 16'h03, 16'h04, "post_rst_add");
    check("post_rst_add_lit", get_s(8), 32'h07);

    // random operations at each width
    widths = '{8, 1, 16};
    foreach (widths[k]) begin
      do_reset();
      mask = (32'd1 << widths[k]) - 32'd1;
      repeat (100) begin
        ra = 16'($urandom & mask);
        rb = 16'($urandom & mask);
        rs = 1'($urandom_range(0, 1));
        rc = 1'($urandom_range(0, 1));
        run_check(widths[k], rs, rc, ra, rb, $sformatf("rnd_w%0d", widths[k]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial, parameterized adder/subtractor with a start/done handshake. It computes {o_c, o_s} = i_a ± i_b ± i_c one bit per clock, LSB first. This trades latency for area against the combinational parameterized adder. It sits beside adder_param in the basic-RTL arithmetic set and shares its operand and result port semantics, so benches can drive both from the same vectors.

## Interface
- BW_DATA, 8, operand and result width in bits; legal range ≥ 1.

- i_clk  input  1  rising-edge clock.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  request to begin an operation; sampled only when the block can accept (see Operation).
- i_sub  input  1  operation select: 0 = add, 1 = subtract; latched with i_start.
- i_a  input  BW_DATA  operand A; latched with i_start.
- i_b  input  BW_DATA  operand B; latched with i_start.
- i_c  input  1  carry-in for add, borrow-in for subtract; latched with i_start.
- o_busy  output  1  high while an operation is in progress (RUN state).
- o_done  output  1  one-cycle pulse; o_s and o_c are valid from this cycle.
- o_s  output  BW_DATA  result sum or difference, registered.
- o_c  output  1  carry-out for add, borrow-out for subtract, registered.

## Operation
- The clock is i_clk. Reset is i_rst, synchronous and active-high.
- State machine states are IDLE, RUN and DONE. The reset state is IDLE.
- **IDLE or DONE, with i_start=1:**
  - Latch A.
  - Latch B' = i_sub ? ~i_b : i_b.
  - Initialise carry register cy = i_sub ? ~i_c : i_c.
  - Clear the bit counter and the internal result shift register.
  - Go to RUN.
- **IDLE or DONE, with i_start=0:** IDLE stays IDLE; DONE goes to IDLE.
- **RUN, each cycle:**
  - Compute bit = A[0] ^ B'[0] ^ cy.
  - Compute the next cy as the majority of (A[0], B'[0], cy).
  - Shift A and B' right by one.
  - Shift bit into the MSB of the internal result register.
  - Increment the counter.
- **RUN, on the cycle that processes bit BW_DATA-1:**
  - Load o_s from the final shifted result.
  - Load o_c = i_sub ? ~cy_final : cy_final.
  - Go to DONE.
- **Arithmetic:**
  - Add: o_c:o_s = i_a + i_b + i_c, exact and unsigned.
  - Subtract: o_s = (i_a − i_b − i_c) mod 2^BW_DATA.
  - Subtract: o_c = 1 iff i_a < i_b + i_c (unsigned borrow).
- **Output timing:** o_s and o_c change only on the completion edge. Between operations they hold the last result; they do not toggle during RUN.
- **o_busy:** equals (state == RUN).
- **o_done:** equals (state == DONE).
- **i_start during RUN:** ignored, with no queueing. Operands changing during RUN have no effect.
- **Back-to-back:** i_start sampled in DONE starts a new operation immediately. o_done is still high for that one cycle.

## Timing
- **Reset values:** state IDLE, o_busy 0, o_done 0, o_s 0, o_c 0. The internal registers and counter are also cleared.
- **Latency:** i_start is sampled at edge E0. o_busy is high after E0. o_done and a valid o_s/o_c appear after edge E(BW_DATA), and o_done drops after E(BW_DATA+1).
- **Throughput:** one operation per BW_DATA+1 cycles with back-to-back starts.
- **BW_DATA = 1:** RUN lasts one cycle, and o_done follows the edge after the start edge.
- **Reset mid-operation:** i_rst=1 at any edge aborts the operation. The next state is IDLE, outputs return to their reset values, and no o_done is produced.
- **Simultaneous i_rst and i_start:** reset wins and the start is dropped.
- The counter width is clog2(BW_DATA+1) bits. The counter never wraps within an operation and is cleared at each accepted start.

## Test plan
All scenarios use BW_DATA = 8 unless stated.
- **Add with carry into MSB:** start add, a=0x7F, b=0x01, c=0. o_busy rises after E0; after E8, o_done=1, o_s=0x80, o_c=0; o_done is low after E9.
- **Add with carry-out:** add, a=0xFF, b=0x01, c=1. o_s=0x01, o_c=1. Between the start and E8, o_s holds the previous value 0x80.
- **Subtract with borrow:**
  - Subtract, a=0x05, b=0x07, c=0: o_s=0xFE, o_c=1.
  - Subtract, a=0x10, b=0x10, c=1: o_s=0xFF, o_c=1.
  - Subtract, a=0x20, b=0x10, c=0: o_s=0x10, o_c=0.
- **Start during RUN:** pulse i_start with a new operand at E3. That start is ignored and the original result is reported at E8. Then pulse i_start during DONE: a second operation starts, and o_done pulses again 8 edges later.
- **Reset mid-operation:** assert i_rst at E4. o_busy, o_done, o_s and o_c are 0 after that edge, and no o_done appears afterwards. A following add, 3+4+0, gives o_s=0x07.
- **Random vectors:** 100 random operations (i_a, i_b, i_c, i_sub), checked against a behavioural model. Repeat the run with BW_DATA=1 and BW_DATA=16.
